serial_accumulator: RTL
=======================

// Module: serial_accumulator
// PURPOSE
//  Upstream neighbour of the delta stage. Sums NN successive beats of NC signed products per channel.
//  Each product is WF bits. Each finished sum is saturated to AW = $clog2(NN)-1+WF bits.
//  The result goes out on an elastic valid/ready port in the layout the delta stage's Accum inputs take.
//  One instance per Accum input; NN selects the fan-in (NP or NN of the network).
// PARAMETERS
//  NC     6      channels per beat (lanes summed in parallel)
//  NN     7      beats per accumulation group; must be >= 2
//  WF     4      product width, signed fixed point
//  BURST  "yes"  "yes": next group accumulates while result waits; "no": input stalls while result held
// PORTS
//  iCLK              in   1          clock
//  iRST              in   1          reset; synchronous, active-high
//  iValid_AM_Prod    in   1          product beat valid
//  oReady_AM_Prod    out  1          product beat ready
//  iData_AM_Prod     in   NC*WF      lane gi at [gi*WF+:WF], signed
//  oValid_BM_Accum   out  1          sum valid
//  iReady_BM_Accum   in   1          sum ready
//  oData_BM_Accum    out  NC*AW      lane gi at [gi*AW+:AW], signed, saturated
// BEHAVIOUR
//  Widths:
//   - SW = WF+$clog2(NN) internal accumulator per lane; it never overflows.
//   - AW = SW-1 output width.
//  Handshakes:
//   - Beat accepted when iValid_AM_Prod & oReady_AM_Prod.
//   - Result taken when oValid_BM_Accum & iReady_BM_Accum.
//  State:
//   - cnt counts 0..NN-1 and wraps to 0 after the last beat.
//   - acc[NC] holds the running sums.
//   - Output register: vld plus data.
//  Accept, cnt==0: acc <= sext(x). Any accepted beat with 0 < cnt: acc <= acc + sext(x).
//  Accept, cnt==NN-1:
//   - Data register <= sat(acc + sext(x)); vld <= 1; cnt <= 0.
//   - Latency: result is valid the cycle after the last beat.
//  Saturation per lane:
//   - Above 2^(AW-1)-1 -> MAX.
//   - Below -2^(AW-1) -> MIN.
//   - Otherwise the low AW bits.
//  Output drain: result taken and no new result loaded -> vld <= 0. Load and take in the same cycle -> vld stays 1, new data.
//  Ready, BURST="yes": oReady = ~(cnt==NN-1 & vld & ~iReady_BM_Accum).
//   - Only the final beat of a group stalls on a held result.
//   - Full throughput: 1 beat/cycle, sustained.
//  Ready, BURST="no": oReady = ~vld (combinational from register, no path from iReady).
//  oValid and oData are registered outputs and do not change while held without ready (AXI-style hold).
//  Reset: cnt=0; acc=0; vld=0; data register=0.
//   - oValid_BM_Accum=0.
//   - oReady_AM_Prod=1 in the cycle after reset.
//   - A partial group or unconsumed result at reset is discarded. iRST wins over every handshake in that cycle.
//  iValid low: nothing changes. Gaps inside a group are allowed at any point.
//  Input beat while iRST is high: ignored.
// STRUCTURE
//  Shared package (network-wide):
//   - Function accw(n,wf) = $clog2(n)-1+wf.
//   - Functions for the MAX/MIN constants of a width.
//   - The delta stage uses the same ones.
//  One sub-module: sat_narrow #(IW,OW). Combinational signed saturate IW->OW, one instance per lane via generate.
//  Counter, accumulators and output register stay in this module.
// TESTING (NC=2, NN=3, WF=4 -> AW=5, range -16..15)
//  1. Beats (1,-1),(2,-2),(3,-3) back-to-back, ready=1 -> one result (6,-6) exactly 1 cycle after beat 3.
//  2. Beats 7,7,7 and -8,-8,-8 on lanes 0/1 -> result (15,-16). Then 5,5,5 -> (15,...) with no wrap.
//  3. Ready low for 4 cycles after a result, BURST="yes":
//     - Two beats of the next group are accepted.
//     - Third beat stalls with oReady=0.
//     - Output data stays stable.
//     - After ready, the next result is correct.
//  4. Same stimulus with BURST="no" -> oReady=0 the whole time vld=1. No beat is lost or doubled; order is kept.
//  5. iRST pulsed after 2 beats of a group:
//     - Next 3 beats (1,1),(1,1),(1,1) -> (3,3).
//     - Stale partial sum does not appear.
//     - oValid=0 during reset and the cycle after.
//  6. Random valid/ready gaps, 1000 groups, scoreboard vs reference model -> all sums match; no handshake violations.

Source files
------------

// File: rtl/serial_accumulator_pkg.sv
// Width and saturation-limit helpers shared by the accumulator and the delta stage.
package serial_accumulator_pkg;

  function automatic int accw(input int n, input int wf);
    return $clog2(n) - 1 + wf;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturation from IW bits down to OW bits.
module sat_narrow
  import serial_accumulator_pkg::*;
#(
  parameter int IW = 6,
  parameter int OW = 5
) (
  input  logic signed [IW-1:0] i_data,
  output logic signed [OW-1:0] o_data
);

  localparam logic signed [IW-1:0] HI = IW'(sat_max(OW));
  localparam logic signed [IW-1:0] LO = IW'(sat_min(OW));

  function automatic logic signed [OW-1:0] sat(input logic signed [IW-1:0] x);
    if (x > HI)      return HI[OW-1:0];
    else if (x < LO) return LO[OW-1:0];
    else             return x[OW-1:0];
  endfunction

  assign o_data = sat(i_data);

endmodule

// File: rtl/serial_accumulator.sv
// Sums NN beats of NC signed lanes, saturates each sum and offers it on an elastic output port.
module serial_accumulator
  import serial_accumulator_pkg::*;
#(
  parameter int    NC    = 6,
  parameter int    NN    = 7,
  parameter int    WF    = 4,
  parameter string BURST = "yes"
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iValid_AM_Prod,
  output logic                       oReady_AM_Prod,
  input  logic [NC*WF-1:0]           iData_AM_Prod,
  output logic                       oValid_BM_Accum,
  input  logic                       iReady_BM_Accum,
  output logic [NC*accw(NN, WF)-1:0] oData_BM_Accum
);

  localparam int AW       = accw(NN, WF);
  localparam int SW       = WF + $clog2(NN);
  localparam int CW       = $clog2(NN);
  localparam bit BURST_EN = (BURST == "yes");

  logic [CW-1:0]        r_cnt;
  logic signed [SW-1:0] r_acc [NC];
  logic                 r_vld;
  logic [NC*AW-1:0]     r_data;

  logic                 w_accept;
  logic                 w_take;
  logic                 w_last;
  logic signed [SW-1:0] w_sum [NC];
  logic [NC*AW-1:0]     w_sat;

  assign w_accept = iValid_AM_Prod & oReady_AM_Prod;
  assign w_take   = r_vld & iReady_BM_Accum;
  assign w_last   = (r_cnt == CW'(NN - 1));

  // The first beat of a group restarts the lane sum instead of adding to it.
  for (genvar gi = 0; gi < NC; gi++) begin : g_lane
    logic signed [WF-1:0] w_x;
    assign w_x        = iData_AM_Prod[gi*WF +: WF];
    assign w_sum[gi]  = (r_cnt == '0) ? SW'(w_x) : r_acc[gi] + SW'(w_x);

    sat_narrow #(
      .IW (SW),
      .OW (AW)
    ) u_sat (
      .i_data (w_sum[gi]),
      .o_data (w_sat[gi*AW +: AW])
    );
  end

  // Burst mode only blocks the group's closing beat while a result is still held.
  if (BURST_EN) begin : g_ready_burst
    assign oReady_AM_Prod = ~(w_last & r_vld & ~iReady_BM_Accum);
  end else begin : g_ready_hold
    assign oReady_AM_Prod = ~r_vld;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
      for (int i = 0; i < NC; i++) r_acc[i] <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        for (int i = 0; i < NC; i++) r_acc[i] <= w_sum[i];
      end
      if (w_accept && w_last) begin
        r_vld  <= 1'b1;
        r_data <= w_sat;
      end else if (w_take) begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign oValid_BM_Accum = r_vld;
  assign oData_BM_Accum  = r_data;

endmodule
